// File: rtl/watch_set_cu.sv
// Set-mode controller for the watch: field select, edit pulses, blink, timeout.
// Every output is a register and answers one clock after the input pulse that causes it.
module watch_set_cu #(
  parameter int TIMEOUT_CYC = 1_000_000_000,
  parameter int BLINK_CYC   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic       i_next,
  input  logic       i_prev,
  input  logic       i_up,
  input  logic       i_down,
  output logic       o_set_mode,
  output logic [1:0] o_field,
  output logic       o_blink,
  output logic       o_hour_p,
  output logic       o_hour_m,
  output logic       o_min_p,
  output logic       o_min_m,
  output logic       o_sec_clr,
  output logic       o_hold
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t          state;
  state_t          ring_nx;
  state_t          ring_pv;
  state_t          step;
  logic [TW-1:0]   tcnt;
  logic [BW-1:0]   bcnt;

  logic nav_any;
  logic nav;
  logic edit_up;
  logic edit_dn;
  logic any_in;
  logic acc;

  // next/prev together is a no-op but still outranks up/down
  assign nav_any = i_next | i_prev;
  assign nav     = i_next ^ i_prev;
  assign edit_up = i_up & ~i_down & ~nav_any;
  assign edit_dn = i_down & ~i_up & ~nav_any;
  assign any_in  = i_set | nav_any | i_up | i_down;
  assign acc     = nav | edit_up | edit_dn;

  assign ring_nx = (state == SET_SEC) ? SET_HOUR
                 : state_t'(state + 2'd1);
  assign ring_pv = (state == SET_HOUR) ? SET_SEC
                 : state_t'(state - 2'd1);
  assign step    = i_next ? ring_nx : ring_pv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      o_set_mode <= 1'b0;
      o_hold     <= 1'b0;
      o_field    <= 2'd0;
      o_blink    <= 1'b1;
      o_hour_p   <= 1'b0;
      o_hour_m   <= 1'b0;
      o_min_p    <= 1'b0;
      o_min_m    <= 1'b0;
      o_sec_clr  <= 1'b0;
    end else begin
      o_hour_p  <= 1'b0;
      o_hour_m  <= 1'b0;
      o_min_p   <= 1'b0;
      o_min_m   <= 1'b0;
      o_sec_clr <= 1'b0;
      if (state == IDLE) begin
        if (i_set) begin
          state      <= SET_HOUR;
          o_field    <= SET_HOUR;
          o_set_mode <= 1'b1;
          o_hold     <= 1'b1;
          o_blink    <= 1'b1;
          tcnt       <= '0;
          bcnt       <= '0;
        end
      end else if (i_set || (!any_in && tcnt == T_LAST)) begin
        state      <= IDLE;
        o_field    <= 2'd0;
        o_set_mode <= 1'b0;
        o_hold     <= 1'b0;
        o_blink    <= 1'b1;
        tcnt       <= '0;
        bcnt       <= '0;
      end else begin
        tcnt <= any_in ? '0 : tcnt + TW'(1);
        if (acc) begin
          bcnt    <= '0;
          o_blink <= 1'b1;
        end else if (bcnt == B_LAST) begin
          bcnt    <= '0;
          o_blink <= ~o_blink;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
        if (nav) begin
          state   <= step;
          o_field <= step;
        end else begin
          unique case (state)
            SET_HOUR: begin
              o_hour_p <= edit_up;
              o_hour_m <= edit_dn;
            end
            SET_MIN: begin
              o_min_p <= edit_up;
              o_min_m <= edit_dn;
            end
            SET_SEC:  o_sec_clr <= edit_up | edit_dn;
            default:  ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_watch_set_cu.sv
// Directed bench for watch_set_cu with short timeout and blink periods.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_watch_set_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_set, i_next, i_prev, i_up, i_down;
  logic       o_set_mode, o_blink, o_hold;
  logic [1:0] o_field;
  logic       o_hour_p, o_hour_m, o_min_p, o_min_m, o_sec_clr;

  int n_chk  = 0;
  int n_fail = 0;

  watch_set_cu #(
    .TIMEOUT_CYC(20),
    .BLINK_CYC  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_set     (i_set),
    .i_next    (i_next),
    .i_prev    (i_prev),
    .i_up      (i_up),
    .i_down    (i_down),
    .o_set_mode(o_set_mode),
    .o_field   (o_field),
    .o_blink   (o_blink),
    .o_hour_p  (o_hour_p),
    .o_hour_m  (o_hour_m),
    .o_min_p   (o_min_p),
    .o_min_m   (o_min_m),
    .o_sec_clr (o_sec_clr),
    .o_hold    (o_hold)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] P_NONE = 32'b00000;
  localparam logic [31:0] P_HP   = 32'b10000;
  localparam logic [31:0] P_SC   = 32'b00001;

  function automatic logic [31:0] pulses();
    return {27'd0, o_hour_p, o_hour_m, o_min_p, o_min_m, o_sec_clr};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one-cycle pulse; returns on the falling edge after it was captured
  task automatic drive(input logic s, input logic n, input logic p,
                       input logic u, input logic d);
    @(negedge clk);
    {i_set, i_next, i_prev, i_up, i_down} = {s, n, p, u, d};
    @(negedge clk);
    {i_set, i_next, i_prev, i_up, i_down} = 5'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mode"},  32'(o_set_mode), 32'd0);
    check({tag, "_field"}, 32'(o_field),    32'd0);
    check({tag, "_blink"}, 32'(o_blink),    32'd1);
    check({tag, "_hold"},  32'(o_hold),     32'd0);
    check({tag, "_pulse"}, pulses(),        P_NONE);
  endtask

  initial begin
    rst = 1'b0;
    {i_set, i_next, i_prev, i_up, i_down} = 5'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    drive(1, 0, 0, 0, 0);
    check("enter_mode",  32'(o_set_mode), 32'd1);
    check("enter_field", 32'(o_field),    32'd1);
    check("enter_hold",  32'(o_hold),     32'd1);
    check("enter_blink", 32'(o_blink),    32'd1);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      check($sformatf("hour_up%0d", i), pulses(), P_HP);
      @(negedge clk);
      check($sformatf("hour_up%0d_end", i), pulses(), P_NONE);
    end

    drive(0, 1, 0, 0, 0);
    check("next_min", 32'(o_field), 32'd2);
    drive(0, 1, 0, 0, 0);
    check("next_sec", 32'(o_field), 32'd3);
    drive(0, 1, 0, 0, 0);
    check("next_wrap", 32'(o_field), 32'd1);
    drive(0, 1, 1, 1, 0);
    check("nextprev_field", 32'(o_field), 32'd1);
    check("nextprev_pulse", pulses(),     P_NONE);
    drive(0, 0, 0, 1, 1);
    check("updown_pulse", pulses(), P_NONE);
    drive(0, 0, 1, 0, 0);
    check("prev_wrap", 32'(o_field), 32'd3);
    drive(0, 0, 0, 0, 1);
    check("sec_clr", pulses(), P_SC);
    @(negedge clk);
    check("sec_clr_end", pulses(), P_NONE);

    drive(0, 0, 1, 0, 0);
    check("prev_min", 32'(o_field), 32'd2);
    drive(1, 0, 0, 1, 0);
    check_idle("set_exit");
    drive(0, 0, 0, 1, 0);
    check_idle("idle_up");
    drive(0, 1, 0, 0, 0);
    check_idle("idle_next");

    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("blink_field", 32'(o_field), 32'd2);
    check("blink_k0",    32'(o_blink), 32'd1);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), 32'(o_blink),
            ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("mode_k%0d", k), 32'(o_set_mode), 32'd1);
    end
    @(negedge clk);
    check_idle("timeout");

    drive(1, 0, 0, 0, 0);
    check("reenter_field", 32'(o_field), 32'd1);
    @(negedge clk);
    i_up = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_pulse", pulses(), P_HP);
    i_up = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
